// File: rtl/syscall_ctl_pkg.sv
// Shared syscall numbers and controller state encoding.
package syscall_ctl_pkg;

  localparam logic [31:0] SYS_HALT  = 32'd0;
  localparam logic [31:0] SYS_CLEAR = 32'd1;
  localparam logic [31:0] SYS_PRINT = 32'd2;

  localparam int TIMER_W = 16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ctl_state_t;

endpackage

// File: rtl/sys_fifo.sv
// Print queue: power-of-two ring buffer, 32-bit entries, head visible on o_data.
module sys_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clr,
  input  logic [31:0]   i_data,
  output logic [31:0]   o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/syscall_ctl.sv
// Syscall controller: decodes HALT/CLEAR/PRINT, holds printed values on the
// display for HOLD_CYCLES edges and gates the CPU run enable.
//   state     | meaning
//   ST_RUN    | CPU running, syscalls accepted while queue not full
//   ST_HALTED | CPU stopped, no syscalls accepted, waits for i_resume
module syscall_ctl
  import syscall_ctl_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [31:0] i_num,
  input  logic [31:0] i_op1,
  input  logic        i_resume,
  output logic        o_ready,
  output logic        o_run,
  output logic [31:0] o_val,
  output logic        o_val_vld,
  output logic        o_busy
);

  localparam int                 CW      = $clog2(DEPTH) + 1;
  localparam logic [TIMER_W-1:0] HOLD_LD = TIMER_W'(HOLD_CYCLES - 1);

  ctl_state_t         state_q;
  logic               run_q;
  logic [31:0]        val_q, val_d;
  logic               val_vld_q, val_vld_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               busy_q, busy_d;

  logic [31:0]   head;
  logic          full, empty;
  logic [CW-1:0] count;
  logic          accept, do_print, do_clear, do_halt, pop;

  assign o_ready = (state_q == ST_RUN) & ~full;
  assign accept  = i_req & o_ready;

  assign do_print = accept & (i_num == SYS_PRINT);
  assign do_clear = accept & (i_num == SYS_CLEAR);
  assign do_halt  = accept & (i_num == SYS_HALT);

  // A CLEAR on the same edge suppresses the pop so the flushed head is never shown.
  assign pop = (timer_q == '0) & ~empty & ~do_clear;

  sys_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (do_print),
    .i_pop   (pop),
    .i_clr   (do_clear),
    .i_data  (i_op1),
    .o_data  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );

  always_comb begin
    val_d     = val_q;
    val_vld_d = val_vld_q;
    timer_d   = timer_q;
    if (do_clear) begin
      val_d     = '0;
      val_vld_d = 1'b0;
      timer_d   = '0;
    end else if (pop) begin
      val_d     = head;
      val_vld_d = 1'b1;
      timer_d   = HOLD_LD;
    end else if (timer_q != '0) begin
      timer_d   = timer_q - 1'b1;
    end
    busy_d = ~do_clear & (do_print | (count > CW'(pop)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      val_q     <= '0;
      val_vld_q <= 1'b0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      val_q     <= val_d;
      val_vld_q <= val_vld_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      run_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_RUN: if (do_halt) begin
          state_q <= ST_HALTED;
          run_q   <= 1'b0;
        end
        ST_HALTED: if (i_resume) begin
          state_q <= ST_RUN;
          run_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_run     = run_q;
  assign o_val     = val_q;
  assign o_val_vld = val_vld_q;
  assign o_busy    = busy_q;

endmodule
